mem_access_unit: RTL and testbench

- MEM-stage load/store engine of the 5-stage RV32I pipeline; sits between the EX/MEM pipeline register and the MEM/WB register.
- Takes the ALU address, store data and funct3, and runs a multi-cycle handshake with data memory.
- Produces the aligned, extended load word as DATA_OUT and the BUSYWAIT that freezes all pipeline registers, including MEM/WB, while an access is in flight.

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_load_align.sv | 37 +++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage load/store engine and its
// load aligner.
package mem_access_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Only meaningful while a request (rd or wr) is present.
    function automatic logic req_fault(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic illegal;
        logic misaligned;
        illegal    = rd ? !(funct3 inside {LB, LH, LW, LBU, LHU})
                        : !(funct3 inside {SB, SH, SW});
        misaligned = (funct3[1:0] == 2'b01 && offset[0]) ||
                     (funct3[1:0] == 2'b10 && offset != 2'b00);
        return (rd & wr) | illegal | misaligned;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store engine (master) and memory (slave).
interface mem_access_unit_if;

    logic        MEM_READ_REQ;
    logic        MEM_WRITE_REQ;
    logic [29:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_READDATA;
    logic        MEM_ACK;

    modport master (
        output MEM_READ_REQ, MEM_WRITE_REQ, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN,
        input  MEM_READDATA, MEM_ACK
    );

    modport slave (
        input  MEM_READ_REQ, MEM_WRITE_REQ, MEM_ADDRESS, MEM_WRITEDATA, MEM_BYTE_EN,
        output MEM_READDATA, MEM_ACK
    );

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it according to funct3.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] readdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        byte_sel = readdata_i[7:0];
        case (offset_i)
            2'd1:    byte_sel = readdata_i[15:8];
            2'd2:    byte_sel = readdata_i[23:16];
            2'd3:    byte_sel = readdata_i[31:24];
            default: byte_sel = readdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? readdata_i[31:16] : readdata_i[15:0];

        data_o = readdata_i;
        case (funct3_i)
            LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
            LH:      data_o = {{16{half_sel[15]}}, half_sel};
            LBU:     data_o = {24'd0, byte_sel};
            LHU:     data_o = {16'd0, half_sel};
            default: data_o = readdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: latches an access, runs the memory handshake
// with a timeout, and returns the extended load word while stalling the pipe.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 7
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MEM_READ,
    input  logic               MEM_WRITE,
    input  logic [2:0]         FUNCT3,
    input  logic [31:0]        ADDRESS,
    input  logic [31:0]        WRITE_DATA,
    output logic [31:0]        DATA_OUT,
    output logic               BUSYWAIT,
    output logic               FAULT,
    output logic               BUS_ERROR,
    mem_access_unit_if.master  mem
);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [2:0]           funct3_q;
    logic [1:0]           offset_q;
    logic                 is_load_q;
    logic [31:0]          data_q;
    logic                 bus_error_q;
    logic                 rd_req_q;
    logic                 wr_req_q;
    logic [29:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           be_q;

    logic                 start;
    logic [3:0]           be_d;
    logic [31:0]          wdata_d;
    logic [31:0]          load_d;

    assign FAULT    = (state_q == IDLE) && (MEM_READ || MEM_WRITE) &&
                      req_fault(MEM_READ, MEM_WRITE, FUNCT3, ADDRESS[1:0]);
    assign start    = (state_q == IDLE) && (MEM_READ || MEM_WRITE) && !FAULT;
    assign BUSYWAIT = start || (state_q == WAIT);

    // Lane placement only needs the size bits; start already excludes illegal codes.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WRITE_DATA;
        if (MEM_WRITE) begin
            case (FUNCT3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << ADDRESS[1:0];
                    wdata_d = {4{WRITE_DATA[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << ADDRESS[1:0];
                    wdata_d = {2{WRITE_DATA[15:0]}};
                end
                default: ;
            endcase
        end
    end

    mem_load_align u_align (
        .readdata_i (mem.MEM_READDATA),
        .offset_i   (offset_q),
        .funct3_i   (funct3_q),
        .data_o     (load_d)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            is_load_q   <= 1'b0;
            data_q      <= '0;
            bus_error_q <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= WAIT;
                        cnt_q     <= '0;
                        funct3_q  <= FUNCT3;
                        offset_q  <= ADDRESS[1:0];
                        is_load_q <= MEM_READ;
                        rd_req_q  <= MEM_READ;
                        wr_req_q  <= MEM_WRITE;
                        addr_q    <= ADDRESS[31:2];
                        wdata_q   <= wdata_d;
                        be_q      <= be_d;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem.MEM_ACK) begin
                        state_q  <= DONE;
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        if (is_load_q) begin
                            data_q <= load_d;
                        end
                    end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= DONE;
                        rd_req_q    <= 1'b0;
                        wr_req_q    <= 1'b0;
                        bus_error_q <= 1'b1;
                    end
                end
                // One non-busy cycle lets the pipeline advance past this instruction.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DATA_OUT          = data_q;
    assign BUS_ERROR         = bus_error_q;
    assign mem.MEM_READ_REQ  = rd_req_q;
    assign mem.MEM_WRITE_REQ = wr_req_q;
    assign mem.MEM_ADDRESS   = addr_q;
    assign mem.MEM_WRITEDATA = wdata_q;
    assign mem.MEM_BYTE_EN   = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random
// accesses compared against an arithmetic reference model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] DATA_OUT;
    logic        BUSYWAIT;
    logic        FAULT;
    logic        BUS_ERROR;

    mem_access_unit_if mem_bus ();

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_data;
    logic        exp_bus_err;

    mem_access_unit #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_WIDTH      (7)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MEM_READ   (MEM_READ),
        .MEM_WRITE  (MEM_WRITE),
        .FUNCT3     (FUNCT3),
        .ADDRESS    (ADDRESS),
        .WRITE_DATA (WRITE_DATA),
        .DATA_OUT   (DATA_OUT),
        .BUSYWAIT   (BUSYWAIT),
        .FAULT      (FAULT),
        .BUS_ERROR  (BUS_ERROR),
        .mem        (mem_bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes and extension.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_fault(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] addr);
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (wr && f3 > 3'd2) return 1'b1;
        return (int'(addr[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic wr, input logic [2:0] f3,
                                            input logic [31:0] addr);
        int v;
        if (!wr) return 4'hF;
        v = ((1 << size_of(f3)) - 1) << int'(addr[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return 32'(wd[7:0]) * 32'h01010101;
            2:       return 32'(wd[15:0]) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                               input logic [1:0] off);
        int          n;
        logic [31:0] mask;
        logic [31:0] v;
        n    = size_of(f3);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (rdata >> (8 * int'(off))) & mask;
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // One access from IDLE. ack_at = WAIT cycle carrying MEM_ACK (0 = never).
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ack_at, input string tag);
        bit flt;
        int busy;
        int k;
        bit done;
        int exp_busy;
        flt = model_fault(rd, wr, f3, addr);
        @(posedge CLK); #1;
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITE_DATA = wd;
        mem_bus.MEM_ACK = 1'b0;
        #1;
        check({tag, ":fault"}, FAULT, flt);
        check({tag, ":busy_idle"}, BUSYWAIT, (rd || wr) && !flt);
        if (flt || !(rd || wr)) begin
            for (int c = 0; c < 2; c++) begin
                @(posedge CLK); #1;
                MEM_READ = 1'b0; MEM_WRITE = 1'b0;
                #1;
                check({tag, ":no_rd_req"}, mem_bus.MEM_READ_REQ, 1'b0);
                check({tag, ":no_wr_req"}, mem_bus.MEM_WRITE_REQ, 1'b0);
                check({tag, ":no_busy"}, BUSYWAIT, 1'b0);
                check({tag, ":data_kept"}, DATA_OUT, exp_data);
            end
            return;
        end
        exp_busy = (ack_at > 0) ? 1 + ack_at : 1 + TIMEOUT;
        busy = 1; k = 0; done = 1'b0;
        while (!done && k < TIMEOUT + 8) begin
            @(posedge CLK); #1;
            k++;
            MEM_READ = 1'b0; MEM_WRITE = 1'b0;
            FUNCT3 = 3'($urandom); ADDRESS = $urandom; WRITE_DATA = $urandom;
            // A second ack during DONE must be ignored.
            mem_bus.MEM_ACK      = (k == ack_at) || (k == exp_busy);
            mem_bus.MEM_READDATA = (k == ack_at) ? rdata : $urandom;
            #1;
            if (BUSYWAIT) begin
                busy++;
                check({tag, ":rd_req"}, mem_bus.MEM_READ_REQ, rd);
                check({tag, ":wr_req"}, mem_bus.MEM_WRITE_REQ, wr);
                if (k == 1) begin
                    check({tag, ":addr"}, mem_bus.MEM_ADDRESS, addr[31:2]);
                    check({tag, ":be"}, mem_bus.MEM_BYTE_EN, model_be(wr, f3, addr));
                    if (wr) check({tag, ":wdata"}, mem_bus.MEM_WRITEDATA, model_wdata(f3, wd));
                end
            end else begin
                done = 1'b1;
            end
        end
        if (ack_at > 0 && rd) exp_data = model_load(rdata, f3, addr[1:0]);
        if (ack_at == 0) exp_bus_err = 1'b1;
        check({tag, ":completed"}, done, 1'b1);
        check({tag, ":busy_cycles"}, busy, exp_busy);
        check({tag, ":done_rd_req"}, mem_bus.MEM_READ_REQ, 1'b0);
        check({tag, ":done_wr_req"}, mem_bus.MEM_WRITE_REQ, 1'b0);
        check({tag, ":data_out"}, DATA_OUT, exp_data);
        check({tag, ":bus_error"}, BUS_ERROR, exp_bus_err);
        @(posedge CLK); #1;
        mem_bus.MEM_ACK = 1'b0;
        #1;
        check({tag, ":idle_busy"}, BUSYWAIT, 1'b0);
        check({tag, ":idle_data"}, DATA_OUT, exp_data);
    endtask

    initial begin
        RESET = 1'b1; MEM_READ = 1'b0; MEM_WRITE = 1'b0; FUNCT3 = 3'd0;
        ADDRESS = '0; WRITE_DATA = '0;
        mem_bus.MEM_ACK = 1'b0; mem_bus.MEM_READDATA = '0;
        exp_data = '0; exp_bus_err = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK); #2;
            check("rst:data_out", DATA_OUT, 32'd0);
            check("rst:busy", BUSYWAIT, 1'b0);
            check("rst:fault", FAULT, 1'b0);
            check("rst:bus_error", BUS_ERROR, 1'b0);
            check("rst:rd_req", mem_bus.MEM_READ_REQ, 1'b0);
            check("rst:wr_req", mem_bus.MEM_WRITE_REQ, 1'b0);
            check("rst:be", mem_bus.MEM_BYTE_EN, 4'd0);
            check("rst:addr", mem_bus.MEM_ADDRESS, 30'd0);
            check("rst:wdata", mem_bus.MEM_WRITEDATA, 32'd0);
        end

        access(1'b1, 1'b0, LB,  32'h1003, '0, 32'h876543F1, 2, "lb");
        check("lb:value", DATA_OUT, 32'hFFFFFF87);
        access(1'b1, 1'b0, LBU, 32'h1000, '0, 32'h876543F1, 2, "lbu");
        check("lbu:value", DATA_OUT, 32'h000000F1);
        access(1'b1, 1'b0, LH,  32'h1002, '0, 32'h876543F1, 2, "lh");
        check("lh:value", DATA_OUT, 32'hFFFF8765);
        access(1'b0, 1'b1, SH,  32'h1002, 32'h1234ABCD, '0, 1, "sh");
        check("sh:data_kept", DATA_OUT, 32'hFFFF8765);
        access(1'b1, 1'b0, LW,  32'h1001, '0, '0, 1, "lw_misaligned");

        for (int i = 0; i < 40; i++) begin
            logic rd, wr;
            int   sel;
            sel = $urandom_range(0, 9);
            rd  = (sel == 0) || (sel >= 2 && sel < 6);
            wr  = (sel == 0) || (sel >= 6);
            access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(1, 6), "rand");
        end

        access(1'b1, 1'b0, LW, 32'h3000, '0, 32'hCAFEF00D, 0, "timeout");
        access(1'b1, 1'b0, LW, 32'h3004, '0, 32'h13579BDF, 1, "after_timeout");
        check("sticky:bus_error", BUS_ERROR, 1'b1);

        // Reset pulsed on the 2nd WAIT cycle of an LW.
        @(posedge CLK); #1;
        MEM_READ = 1'b1; FUNCT3 = LW; ADDRESS = 32'h2000;
        #1 check("rst_wait:busy_idle", BUSYWAIT, 1'b1);
        @(posedge CLK); #1;
        MEM_READ = 1'b0;
        #1 check("rst_wait:rd_req", mem_bus.MEM_READ_REQ, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0; mem_bus.MEM_ACK = 1'b1; mem_bus.MEM_READDATA = 32'hDEADBEEF;
        exp_data = '0; exp_bus_err = 1'b0;
        #1;
        check("rst_wait:rd_req_drop", mem_bus.MEM_READ_REQ, 1'b0);
        check("rst_wait:busy", BUSYWAIT, 1'b0);
        check("rst_wait:data_out", DATA_OUT, exp_data);
        check("rst_wait:bus_error", BUS_ERROR, exp_bus_err);
        @(posedge CLK); #1;
        mem_bus.MEM_ACK = 1'b0;
        #1;
        check("rst_wait:late_ack_data", DATA_OUT, exp_data);
        check("rst_wait:late_ack_req", mem_bus.MEM_READ_REQ, 1'b0);
        check("rst_wait:late_ack_busy", BUSYWAIT, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
